fetch_unit: RTL and testbench

//  Program-counter / fetch stage directly upstream of imem: owns the 8-bit PC

---
 rtl/fetch_pkg.sv | 41 ++++
 rtl/fetch_unit_branch_lut.sv | 39 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the program-counter / fetch stage.
//
//   Contents:
//     fetch_state_t  - sequencing state of the fetch stage (IDLE, RUN, DONE)
//     PC_W           - program-counter width; the PC wraps modulo 2**PC_W
//     LUT_IDX_W      - branch-target LUT index width (16 entries)
//     CNT_W          - RUN-cycle counter width
//     TGT_*          - branch targets of the resident programs, one per LUT
//                      entry; entries 11..15 are unused and resolve to 0
//
//   Optional feature macro used by fetch_unit: FETCH_CYCLE_CNT_EN
// ---------------------------------------------------------------------------
package fetch_pkg;

   parameter int PC_W      = 8;
   parameter int LUT_IDX_W = 4;
   parameter int CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   // Branch targets, named after the labels they land on in the programs.
   localparam logic [PC_W-1:0] TGT_LOOP        = 8'd2;
   localparam logic [PC_W-1:0] TGT_LOWERLOOP   = 8'd21;
   localparam logic [PC_W-1:0] TGT_STRINGLOOP  = 8'd26;
   localparam logic [PC_W-1:0] TGT_MATCHLOOP   = 8'd29;
   localparam logic [PC_W-1:0] TGT_FOUND       = 8'd39;
   localparam logic [PC_W-1:0] TGT_INCJ        = 8'd40;
   localparam logic [PC_W-1:0] TGT_OUTER       = 8'd46;
   localparam logic [PC_W-1:0] TGT_INNER       = 8'd48;
   localparam logic [PC_W-1:0] TGT_IJSUB       = 8'd53;
   localparam logic [PC_W-1:0] TGT_COMPDIST    = 8'd54;
   localparam logic [PC_W-1:0] TGT_INCJ_PAIR   = 8'd57;
   localparam logic [PC_W-1:0] TGT_UNUSED      = 8'd0;

endpackage : fetch_pkg

// File: rtl/fetch_unit_branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut
//   Combinational branch-target lookup. Maps a LUT index supplied by the
//   decoder to the absolute PC of the branch destination.
//
//   Ports:
//     idx    in   LUT_IDX_W  target-LUT index
//     target out  PC_W       absolute branch target PC
//
//   Indices 11..15 have no program label behind them and return PC 0; a
//   branch through one of them simply restarts at address 0.
// ---------------------------------------------------------------------------
module branch_lut
   import fetch_pkg::*;
(
   input  logic [LUT_IDX_W-1:0] idx,
   output logic [PC_W-1:0]      target
);

   // Pure table lookup; the default arm covers every unused index.
   always_comb begin
      target = TGT_UNUSED;
      case (idx)
         4'd0:    target = TGT_LOOP;
         4'd1:    target = TGT_LOWERLOOP;
         4'd2:    target = TGT_STRINGLOOP;
         4'd3:    target = TGT_MATCHLOOP;
         4'd4:    target = TGT_FOUND;
         4'd5:    target = TGT_INCJ;
         4'd6:    target = TGT_OUTER;
         4'd7:    target = TGT_INNER;
         4'd8:    target = TGT_IJSUB;
         4'd9:    target = TGT_COMPDIST;
         4'd10:   target = TGT_INCJ_PAIR;
         default: target = TGT_UNUSED;
      endcase
   end

endmodule : branch_lut

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Program-counter / fetch stage sitting directly in front of a
//   combinational instruction memory. Owns the PC, launches a program at a
//   given start address, steps it sequentially, applies stalls and taken
//   branches (targets resolved through branch_lut) and stops when the decoder
//   reports the done word.
//
//   Ports:
//     Clk        in   1          system clock, rising edge
//     Reset      in   1          asynchronous active-high reset
//     Start      in   1          launch pulse, honoured only in IDLE or DONE
//     StartAddr  in   PC_W       first PC of the program
//     Stall      in   1          hold the PC this cycle
//     BranchEn   in   1          current instruction is a taken branch
//     BranchIdx  in   LUT_IDX_W  branch-target LUT index
//     HaltReq    in   1          decoder sees the done word
//     PC         out  PC_W       instruction-memory address
//     Running    out  1          high exactly while in RUN
//     Done       out  1          high from halt until the next accepted Start
//     CycleCnt   out  CNT_W      RUN-cycle count (0 unless the macro is set)
//
//   Optional feature: define FETCH_CYCLE_CNT_EN to build the saturating
//   RUN-cycle counter behind CycleCnt. Without it CycleCnt is tied to 0.
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [PC_W-1:0]      StartAddr,
   input  logic                 Stall,
   input  logic                 BranchEn,
   input  logic [LUT_IDX_W-1:0] BranchIdx,
   input  logic                 HaltReq,
   output logic [PC_W-1:0]      PC,
   output logic                 Running,
   output logic                 Done,
   output logic [CNT_W-1:0]     CycleCnt
);

   fetch_state_t    state;
   logic [PC_W-1:0] branch_target;

   branch_lut u_branch_lut (
      .idx    (BranchIdx),
      .target (branch_target)
   );

   // Sequencer and PC. Running and Done are registered alongside the state
   // so they always agree with it. In RUN, halt wins over stall, and stall
   // wins over a branch, so a branch arriving during a stall is dropped.
   // The halt leaves the PC parked on the done word's address.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         PC      <= '0;
         Running <= 1'b0;
         Done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state   <= RUN;
                  PC      <= StartAddr;
                  Running <= 1'b1;
                  Done    <= 1'b0;
               end
            end
            RUN: begin
               if (HaltReq) begin
                  state   <= DONE;
                  Running <= 1'b0;
                  Done    <= 1'b1;
               end else if (Stall) begin
                  PC <= PC;
               end else if (BranchEn) begin
                  PC <= branch_target;
               end else begin
                  PC <= PC + PC_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               Running <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_CYCLE_CNT_EN
   logic [CNT_W-1:0] cycle_cnt;

   // Counts every cycle spent in RUN, stalls and the halting cycle included.
   // A launch clears it; it saturates at all-ones and is left untouched in
   // DONE so software can read the final figure.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cycle_cnt <= '0;
      end else if (state == RUN) begin
         if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end
      end else if (Start) begin
         cycle_cnt <= '0;
      end
   end

   assign CycleCnt = cycle_cnt;
`else
   assign CycleCnt = '0;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural reference tracks the
//   architectural picture (running/done flags, PC as an integer, cycle count)
//   and is compared with the DUT on every falling edge. Directed sequences
//   pin known PC values by hand, then a randomized phase exercises the mix
//   of starts, stalls, branches and halts.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   import fetch_pkg::*;

   logic                 Clk = 1'b0;
   logic                 Reset = 1'b1;
   logic                 Start = 1'b0;
   logic [PC_W-1:0]      StartAddr = '0;
   logic                 Stall = 1'b0;
   logic                 BranchEn = 1'b0;
   logic [LUT_IDX_W-1:0] BranchIdx = '0;
   logic                 HaltReq = 1'b0;
   logic [PC_W-1:0]      PC;
   logic                 Running;
   logic                 Done;
   logic [CNT_W-1:0]     CycleCnt;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   // Reference state kept as plain integers.
   int m_pc   = 0;
   bit m_run  = 1'b0;
   bit m_done = 1'b0;
   int m_cnt  = 0;
   int lut [16] = '{2, 21, 26, 29, 39, 40, 46, 48, 53, 54, 57, 0, 0, 0, 0, 0};

   fetch_unit dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .StartAddr (StartAddr),
      .Stall     (Stall),
      .BranchEn  (BranchEn),
      .BranchIdx (BranchIdx),
      .HaltReq   (HaltReq),
      .PC        (PC),
      .Running   (Running),
      .Done      (Done),
      .CycleCnt  (CycleCnt)
   );

   always #5 Clk = ~Clk;

   // Reference behaviour: one architectural step per rising edge.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_pc = 0; m_run = 1'b0; m_done = 1'b0; m_cnt = 0;
      end else if (m_run) begin
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (HaltReq) begin
            m_run = 1'b0; m_done = 1'b1;
         end else if (!Stall) begin
            if (BranchEn) m_pc = lut[BranchIdx];
            else          m_pc = (m_pc + 1) % 256;
         end
      end else if (Start) begin
         m_run = 1'b1; m_done = 1'b0; m_pc = int'(StartAddr); m_cnt = 0;
      end
   end

   function automatic int expCnt(input int c);
`ifdef FETCH_CYCLE_CNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   // Continuous comparison against the reference on every falling edge.
   always @(negedge Clk) begin
      if (cmp_en && !Reset) begin
         n_checks++;
         if (int'(PC) == m_pc && Running == m_run && Done == m_done &&
             int'(CycleCnt) == expCnt(m_cnt)) begin
            n_pass++;
         end else begin
            $display("[TB] FAIL model t=%0t got pc=%0d run=%0b done=%0b cnt=%0d expected pc=%0d run=%0b done=%0b cnt=%0d",
                     $time, PC, Running, Done, CycleCnt, m_pc, m_run, m_done, expCnt(m_cnt));
         end
      end
   end

   // Drive one cycle of inputs, let the rising edge act, return on the
   // following falling edge.
   task automatic applyStimulus(input bit st, input int addr, input bit stl,
                                input bit br, input int idx, input bit hlt);
      Start     = st;
      StartAddr = PC_W'(addr);
      Stall     = stl;
      BranchEn  = br;
      BranchIdx = LUT_IDX_W'(idx);
      HaltReq   = hlt;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic stepN(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   // Hand-computed literal expectation.
   task automatic checkOutput(input string name, input int pc, input bit run,
                              input bit done, input int cnt);
      n_checks++;
      if (int'(PC) == pc && Running == run && Done == done &&
          int'(CycleCnt) == expCnt(cnt)) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s got pc=%0d run=%0b done=%0b cnt=%0d expected pc=%0d run=%0b done=%0b cnt=%0d",
                  name, PC, Running, Done, CycleCnt, pc, run, done, expCnt(cnt));
      end
   endtask

   task automatic pulseReset();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      checkOutput("reset", 0, 0, 0, 0);
      cmp_en = 1'b1;

      // Launch at 0 and step sequentially.
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("start0", 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("seq1", 1, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("seq2", 2, 1, 0, 2);
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("seq3", 3, 1, 0, 3);
      stepN(12);
      checkOutput("pc15", 15, 1, 0, 15);

      // Stall outranks branch; then the branch is taken.
      applyStimulus(0, 0, 1, 1, 0, 0); checkOutput("stall_br", 15, 1, 0, 16);
      applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("branch0", 2, 1, 0, 17);

      // Halt at 25, hold, relaunch at 26.
      stepN(23);
      applyStimulus(0, 0, 0, 0, 0, 1); checkOutput("halt25", 25, 0, 1, 41);
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("done_hold", 25, 0, 1, 41);
      applyStimulus(1, 26, 0, 0, 0, 0); checkOutput("relaunch26", 26, 1, 0, 0);

      // Start ignored in RUN; halt beats branch at 44.
      applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("start_in_run", 27, 1, 0, 1);
      stepN(17);
      applyStimulus(0, 0, 0, 1, 3, 1); checkOutput("halt_br44", 44, 0, 1, 19);

      // Cycle count: 3 RUN cycles with one stall, then the halt cycle.
      pulseReset();
      checkOutput("reset2", 0, 0, 0, 0);
      applyStimulus(1, 45, 0, 0, 0, 0); checkOutput("start45", 45, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1); checkOutput("cnt_halt", 47, 0, 1, 4);
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("cnt_held", 47, 0, 1, 4);

      // PC wrap and branch through an unused LUT entry.
      applyStimulus(1, 45, 0, 0, 0, 0);
      stepN(210);
      checkOutput("pc255", 255, 1, 0, 210);
      applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("wrap0", 0, 1, 0, 211);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 12, 0); checkOutput("unused_lut", 0, 1, 0, 213);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Reset asserted between edges acts without waiting for a clock.
      @(posedge Clk);
      #2 Reset = 1'b1;
      #1 checkOutput("async_reset", 0, 0, 0, 0);
      #1 Reset = 1'b0;
      @(negedge Clk);

      // Randomized phase checked by the continuous compare.
      for (int i = 0; i < 600; i++) begin
         int sel;
         int addr;
         sel = int'($urandom_range(0, 3));
         addr = (sel == 0) ? 0 : (sel == 1) ? 26 : (sel == 2) ? 45 : int'($urandom_range(0, 255));
         applyStimulus($urandom_range(0, 5) == 0, addr,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                       int'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
         if (i == 300) pulseReset();
      end

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fetch_unit
